demux_1_4_stream: RTL and testbench
===================================

DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of input and each output channel.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port In_data  input  WIDTH  word to route.
REQ-005 SHALL have port In_sel  input  2  destination channel, 0..3; Sel bit 1 is MSB.
REQ-006 SHALL have port In_valid  input  1  In_data/In_sel valid this cycle.
REQ-007 SHALL have port In_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have ports Out0..Out3  output  WIDTH each  per-channel registered data.
REQ-009 SHALL have port Out_valid  output  4  bit n = channel n holds a word.
REQ-010 SHALL have port Out_ready  input  4  bit n = channel n consumer takes word.
REQ-011 SHALL have ports Cnt0..Cnt3  output  16 each  per-channel accepted-transfer count.

Function
REQ-012 SHALL hold per channel one-entry register, states EMPTY (Out_valid[n]=0) and FULL (Out_valid[n]=1).
REQ-013 SHALL drive In_ready = ~Out_valid[In_sel] | Out_ready[In_sel], combinational, no dependence on In_valid.
REQ-014 SHALL accept a word when In_valid & In_ready at a rising edge; word loads into channel In_sel.
REQ-015 SHALL present accepted word on Out<In_sel> with Out_valid bit set on the cycle after acceptance (latency 1).
REQ-016 SHALL move FULL->EMPTY when Out_valid[n] & Out_ready[n] and no load into n that edge.
REQ-017 SHALL, on simultaneous drain and load of same channel, load new word and remain FULL (no bubble, full throughput per channel).
REQ-018 SHALL hold Out<n> and Out_valid[n] stable while FULL and Out_ready[n]=0.
REQ-019 SHALL retain last Out<n> value while EMPTY (data not cleared on drain).
REQ-020 SHALL leave unselected channels unaffected by input activity; drains of other channels proceed independently same cycle.
REQ-021 SHALL accept at most one word per cycle; In_sel sampled only on acceptance.
REQ-022 SHALL deassert In_ready when selected channel FULL and not draining; no input state changes while In_valid=0.

Reset
REQ-023 SHALL, while Reset=1 at a rising edge, clear Out_valid to 4'b0000, Out0..Out3 to 0, Cnt0..Cnt3 to 0.
REQ-024 SHALL discard any word held or presented during reset; no acceptance occurs on a reset edge.
REQ-025 SHALL drive In_ready=1 on the first cycle after Reset deasserts (all channels EMPTY).

Configuration
REQ-026 SHALL use macro DEMUX_1_4_STREAM_CNT_EN to compile in transfer counters.
REQ-027 SHALL, with macro defined, increment Cnt<n> by 1 on each acceptance into channel n, wrap 16'hFFFF->16'h0000.
REQ-028 SHALL, without macro, keep Cnt0..Cnt3 ports present and tied to 0, no counter registers.

Verification
REQ-029 SHALL cover: reset, then In_data=8'hA5, In_sel=2, In_valid=1, Out_ready=0 -> next cycle Out2=8'hA5, Out_valid=4'b0100, others unchanged.
REQ-030 SHALL cover: channel 1 FULL, Out_ready[1]=0, In_sel=1, In_valid=1 -> In_ready=0, Out1 held for 5 cycles; raise Out_ready[1] -> In_ready=1, new word in Out1 next cycle, Out_valid[1] stays 1.
REQ-031 SHALL cover: channel 0 FULL and blocked, In_sel=3 word 8'h3C -> accepted, Out3=8'h3C, Out0 unchanged.
REQ-032 SHALL cover: Out_ready=4'hF, words 0..3 sent to sel 0,1,2,3 on consecutive cycles -> one acceptance per cycle, each Out_valid bit high exactly one cycle.
REQ-033 SHALL cover: Reset asserted while channels 0 and 2 FULL -> next cycle Out_valid=0, Out0..Out3=0, In_ready=1.
REQ-034 SHALL cover (macro defined): 65537 acceptances into channel 0 -> Cnt0=1, Cnt1..Cnt3=0; macro undefined -> all Cnt=0.

Source files
------------

// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream demultiplexer with a one-entry skid-free register per output channel.
// Optional per-channel transfer counters are compiled in with DEMUX_1_4_STREAM_CNT_EN.
module demux_1_4_stream #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] In_data,
   input  logic [1:0]       In_sel,
   input  logic             In_valid,
   output logic             In_ready,
   output logic [WIDTH-1:0] Out0,
   output logic [WIDTH-1:0] Out1,
   output logic [WIDTH-1:0] Out2,
   output logic [WIDTH-1:0] Out3,
   output logic [3:0]       Out_valid,
   input  logic [3:0]       Out_ready,
   output logic [15:0]      Cnt0,
   output logic [15:0]      Cnt1,
   output logic [15:0]      Cnt2,
   output logic [15:0]      Cnt3
);

   typedef enum logic {
      StEmpty = 1'b0,
      StFull  = 1'b1
   } ch_state_e;

   ch_state_e        state_q [4];
   ch_state_e        state_d [4];
   logic [WIDTH-1:0] data_q  [4];
   logic [WIDTH-1:0] data_d  [4];
   logic [3:0]       load;
   logic             accept;

   // Ready depends only on the selected channel, never on In_valid.
   always_comb begin
      In_ready = (state_q[In_sel] == StEmpty) | Out_ready[In_sel];
      accept   = In_valid & In_ready;
   end

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         load[n]    = accept & (In_sel == 2'(n));
         state_d[n] = state_q[n];
         data_d[n]  = data_q[n];
         if (load[n]) begin
            // A load wins over a same-cycle drain, so the channel stays full.
            state_d[n] = StFull;
            data_d[n]  = In_data;
         end else if ((state_q[n] == StFull) && Out_ready[n]) begin
            state_d[n] = StEmpty;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int n = 0; n < 4; n++) begin
            state_q[n] <= StEmpty;
            data_q[n]  <= '0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            state_q[n] <= state_d[n];
            data_q[n]  <= data_d[n];
         end
      end
   end

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         Out_valid[n] = (state_q[n] == StFull);
      end
      Out0 = data_q[0];
      Out1 = data_q[1];
      Out2 = data_q[2];
      Out3 = data_q[3];
   end

`ifdef DEMUX_1_4_STREAM_CNT_EN
   logic [15:0] cnt_q [4];
   logic [15:0] cnt_d [4];

   // Counters wrap naturally at 16 bits.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         cnt_d[n] = cnt_q[n] + 16'(load[n]);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int n = 0; n < 4; n++) begin
            cnt_q[n] <= '0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            cnt_q[n] <= cnt_d[n];
         end
      end
   end

   always_comb begin
      Cnt0 = cnt_q[0];
      Cnt1 = cnt_q[1];
      Cnt2 = cnt_q[2];
      Cnt3 = cnt_q[3];
   end
`else
   always_comb begin
      Cnt0 = '0;
      Cnt1 = '0;
      Cnt2 = '0;
      Cnt3 = '0;
   end
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed bench for demux_1_4_stream: per-channel expected-word queues plus a small
// state model checked every cycle; counter checks follow DEMUX_1_4_STREAM_CNT_EN.
module tb_demux_1_4_stream;

   logic        clk;
   logic        reset;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out0, out1, out2, out3;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] cnt0, cnt1, cnt2, cnt3;

   demux_1_4_stream #(.WIDTH(8)) dut (
      .Clk       (clk),
      .Reset     (reset),
      .In_data   (in_data),
      .In_sel    (in_sel),
      .In_valid  (in_valid),
      .In_ready  (in_ready),
      .Out0      (out0),
      .Out1      (out1),
      .Out2      (out2),
      .Out3      (out3),
      .Out_valid (out_valid),
      .Out_ready (out_ready),
      .Cnt0      (cnt0),
      .Cnt1      (cnt1),
      .Cnt2      (cnt2),
      .Cnt3      (cnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned passed = 0;
   int unsigned total  = 0;

   logic [3:0]  mv = 4'b0000;
   logic [7:0]  md [4];
   logic [15:0] mcnt [4];
   logic        known = 1'b0;
   logic [7:0]  sbq [4][$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] out_of(input int n);
      case (n)
         0:       return out0;
         1:       return out1;
         2:       return out2;
         default: return out3;
      endcase
   endfunction

   function automatic logic [15:0] cnt_of(input int n);
      case (n)
         0:       return cnt0;
         1:       return cnt1;
         2:       return cnt2;
         default: return cnt3;
      endcase
   endfunction

   // Called at a negedge with this cycle's inputs already driven; returns at the next negedge.
   task automatic cyc();
      logic       er;
      logic       acc;
      logic [7:0] w;
      #1;
      er = !mv[in_sel] || out_ready[in_sel];
      if (known) begin
         chk("in_ready", 32'(in_ready), 32'(er));
         chk("out_valid", 32'(out_valid), 32'(mv));
         for (int n = 0; n < 4; n++) begin
            chk($sformatf("out%0d", n), 32'(out_of(n)), 32'(md[n]));
`ifdef DEMUX_1_4_STREAM_CNT_EN
            chk($sformatf("cnt%0d", n), 32'(cnt_of(n)), 32'(mcnt[n]));
`else
            chk($sformatf("cnt%0d_tied", n), 32'(cnt_of(n)), 32'h0);
`endif
         end
      end
      if (reset) begin
         mv    = 4'b0000;
         known = 1'b1;
         for (int n = 0; n < 4; n++) begin
            md[n]   = 8'h00;
            mcnt[n] = 16'h0000;
            sbq[n].delete();
         end
      end else if (known) begin
         acc = in_valid && er;
         for (int n = 0; n < 4; n++) begin
            if (mv[n] && out_ready[n]) begin
               chk($sformatf("sb_depth%0d", n), 32'(sbq[n].size()), 32'd1);
               if (sbq[n].size() > 0) begin
                  w = sbq[n].pop_front();
                  chk($sformatf("drain%0d", n), 32'(out_of(n)), 32'(w));
               end
            end
            if (acc && (in_sel == 2'(n))) begin
               mv[n]   = 1'b1;
               md[n]   = in_data;
               mcnt[n] = mcnt[n] + 16'd1;
               sbq[n].push_back(in_data);
            end else if (out_ready[n]) begin
               mv[n] = 1'b0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      @(negedge clk);
      cyc();
      cyc();
      reset = 1'b0;

      // Single word to channel 2, consumer blocked.
      drive(1'b1, 2'd2, 8'hA5, 4'h0);
      cyc();
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      cyc();
      chk("a5_out2", 32'(out2), 32'hA5);
      chk("a5_valid", 32'(out_valid), 32'h4);

      // Channel 1 full and blocked: back-pressure for 5 cycles, then drain+load.
      drive(1'b1, 2'd1, 8'h11, 4'h0);
      cyc();
      drive(1'b1, 2'd1, 8'h22, 4'h0);
      for (int i = 0; i < 5; i++) cyc();
      drive(1'b1, 2'd1, 8'h22, 4'b0010);
      cyc();
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      cyc();
      chk("swap_out1", 32'(out1), 32'h22);
      chk("swap_valid1", 32'(out_valid[1]), 32'h1);

      // Blocked channel 0 does not stop a word to channel 3.
      drive(1'b1, 2'd0, 8'h55, 4'h0);
      cyc();
      drive(1'b1, 2'd3, 8'h3C, 4'h0);
      cyc();
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      cyc();
      chk("indep_out3", 32'(out3), 32'h3C);
      chk("indep_out0", 32'(out0), 32'h55);

      // Full throughput: one word per cycle round-robin with all consumers ready.
      drive(1'b0, 2'd0, 8'h00, 4'hF);
      cyc();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'(i), 8'(i), 4'hF);
         cyc();
      end
      drive(1'b0, 2'd0, 8'h00, 4'hF);
      cyc();
      cyc();

      // Reset while channels 0 and 2 are full.
      drive(1'b1, 2'd0, 8'h77, 4'h0);
      cyc();
      drive(1'b1, 2'd2, 8'h88, 4'h0);
      cyc();
      reset = 1'b1;
      drive(1'b1, 2'd1, 8'h99, 4'h0);
      cyc();
      reset = 1'b0;
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      cyc();
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h1);
      chk("rst_out0", 32'(out0), 32'h0);
      chk("rst_out2", 32'(out2), 32'h0);

      // Pseudo-random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
               4'($urandom));
         cyc();
      end

`ifdef DEMUX_1_4_STREAM_CNT_EN
      reset = 1'b1;
      drive(1'b0, 2'd0, 8'h00, 4'hF);
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 65537; i++) begin
         drive(1'b1, 2'd0, 8'(i), 4'hF);
         cyc();
      end
      drive(1'b0, 2'd0, 8'h00, 4'hF);
      cyc();
      chk("cnt0_wrap", 32'(cnt0), 32'h1);
      chk("cnt1_wrap", 32'(cnt1), 32'h0);
`else
      chk("cnt0_off", 32'(cnt0), 32'h0);
      chk("cnt3_off", 32'(cnt3), 32'h0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
